v_chunk_tx_framer: RTL and testbench
====================================

Name: v_chunk_tx_framer

Overview:
- Downstream stage of the virtual-peripheral chunk producers (the LED-state source and its siblings).
- Consumes each source's pending-update flag, chunk type and chunk byte, and arbitrates round-robin among NUM_SOURCES producers.
- Serialises the granted chunk as a 4-byte frame onto a valid/ready byte stream feeding the UART transmitter.
- Pulses a one-cycle acknowledge back to the granted source, wired to that producer's update-clear input.

Parameters:
- NUM_SOURCES, 4, number of chunk producers; legal range 1..8.
- SYNC_BYTE, 8'h7E, first byte of every frame.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- src_should_update  input  NUM_SOURCES  bit i high = source i has a pending chunk.
- src_chunk_type  input  8*NUM_SOURCES  source i type in bits [8i+7:8i].
- src_chunk_bytes  input  8*NUM_SOURCES  source i payload in bits [8i+7:8i].
- src_ack  output  NUM_SOURCES  one-hot, one-cycle pulse; frame for source i fully accepted downstream.
- tx_data  output  8  current frame byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  downstream accepts tx_data this cycle when tx_valid=1.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values while RST_N=0 (asserted asynchronously): state=IDLE, tx_valid=0, tx_data=0, src_ack=0, busy=0, rr pointer=0, captured type/data=0. Reset mid-frame abandons the frame; no ack is issued and no partial-frame resumption occurs.
- Frame format: SYNC_BYTE, TYPE, DATA, CSUM with CSUM = TYPE ^ DATA (8-bit XOR).
- FSM states: IDLE, SYNC, TYPE, DATA, CSUM, ACK.
- IDLE:
  - If any src_should_update bit is set, grant the lowest index >= rr pointer, wrapping modulo NUM_SOURCES.
  - On the grant edge, capture the granted type and data into registers; later source changes do not affect the frame.
  - Then go to SYNC.
- SYNC/TYPE/DATA/CSUM:
  - tx_valid=1 and tx_data is the matching frame byte.
  - Advance only on the edge where tx_valid && tx_ready.
  - While tx_ready=0, tx_data and tx_valid hold stable; there is no timeout.
- CSUM accepted: go to ACK.
- ACK:
  - tx_valid=0; src_ack[grant]=1 for exactly this cycle.
  - rr pointer <= (grant+1) mod NUM_SOURCES.
  - Next state is IDLE.
- Because the source clears its flag on the ack edge, IDLE never re-grants the same request. A request that re-raises later is served again only in round-robin order.
- Latency: request visible in IDLE -> tx_valid high 1 cycle later. With tx_ready held 1, a frame takes 6 cycles grant-to-IDLE. Back-to-back frames have one idle cycle between ACK and the next SYNC.
- Requests arriving during a frame are held pending by the sources; no loss, no queueing in this block.
- Simultaneous requests: the rr pointer decides order. With all sources requesting continuously, each source is served once per NUM_SOURCES frames.
- NUM_SOURCES=1: the pointer stays 0 and grant is always 0.
- tx_valid is never deasserted while tx_ready=0 before acceptance.

Decomposition:
- Shared package: frame-state encoding, SYNC_BYTE default, frame length constant (4), and chunk-type constants for each virtual peripheral (LEDs = 2, etc.).
- One sub-module, v_rr_arbiter: request vector plus pointer in, one-hot grant plus index out, purely combinational.
- FSM and capture registers stay in the top module.

Test Plan:
- Single source 0 (type 2, data 8'hA5), tx_ready=1 -> bytes 7E,02,A5,A7 on consecutive cycles, then src_ack[0] one cycle, busy low after.
- Backpressure: tx_ready=0 for 5 cycles during TYPE -> tx_data=02 and tx_valid held 5 cycles, no byte skipped, CSUM still correct.
- Sources 1 and 3 request together, pointer=0 -> frame for 1 then 3. Repeat with both requesting -> order 1,3 again (pointer wraps). Acks are one-hot and in that order.
- Source payload changes from 8'h10 to 8'h20 mid-frame -> frame carries 10, CSUM = type^10.
- RST_N low during DATA -> tx_valid, busy, src_ack drop immediately. After release, the pending source is re-framed from SYNC.
- All 4 sources requesting for 8 frames -> grants 0,1,2,3,0,1,2,3, each frame separated by exactly one idle cycle.

Source files
------------

// File: rtl/v_chunk_tx_framer_pkg.sv
// rtl/v_chunk_tx_framer_pkg.sv - shared frame states, constants and checksum helper for the chunk TX framer
package v_chunk_tx_framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_TYPE = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4,
      ST_ACK  = 3'd5
   } frame_state_e;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h7E;
   localparam int         FRAME_LEN         = 4;

   // Chunk type codes used by the virtual-peripheral producers
   localparam logic [7:0] CHUNK_TYPE_BUTTONS  = 8'd1;
   localparam logic [7:0] CHUNK_TYPE_LEDS     = 8'd2;
   localparam logic [7:0] CHUNK_TYPE_SWITCHES = 8'd3;
   localparam logic [7:0] CHUNK_TYPE_SEG7     = 8'd4;

   function automatic logic [7:0] frame_csum(input logic [7:0] chunk_type, input logic [7:0] chunk_data);
      return chunk_type ^ chunk_data;
   endfunction

endpackage

// File: rtl/v_rr_arbiter.sv
// rtl/v_rr_arbiter.sv - combinational round-robin pick: lowest requesting index at or above ptr, wrapping
module v_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   localparam int CW = IDX_W + 1;

   logic [CW-1:0] cand;

   always_comb begin
      cand        = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int off = 0; off < N; off++) begin
         cand = {1'b0, ptr} + CW'(off);
         if (cand >= CW'(N)) begin
            cand = cand - CW'(N);
         end
         if (!grant_valid && req[cand[IDX_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[IDX_W-1:0];
         end
      end
      grant = grant_valid ? (N'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/v_chunk_tx_framer.sv
// rtl/v_chunk_tx_framer.sv - arbitrates chunk producers and serialises SYNC/TYPE/DATA/CSUM frames onto a byte stream
module v_chunk_tx_framer
   import v_chunk_tx_framer_pkg::*;
#(
   parameter int         NUM_SOURCES = 4,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [NUM_SOURCES-1:0]   src_should_update,
   input  logic [8*NUM_SOURCES-1:0] src_chunk_type,
   input  logic [8*NUM_SOURCES-1:0] src_chunk_bytes,
   output logic [NUM_SOURCES-1:0]   src_ack,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     busy
);

   localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

   frame_state_e     state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [7:0]       type_q, type_d;
   logic [7:0]       data_q, data_d;

   logic [NUM_SOURCES-1:0] arb_grant;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_valid;

   v_rr_arbiter #(
      .N     (NUM_SOURCES),
      .IDX_W (IDX_W)
   ) u_arb (
      .req         (src_should_update),
      .ptr         (ptr_q),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      type_d   = type_q;
      data_d   = data_q;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      src_ack  = '0;
      busy     = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               grant_d = arb_idx;
               // Payload is frozen here so producers may change it freely mid-frame
               for (int i = 0; i < NUM_SOURCES; i++) begin
                  if (arb_grant[i]) begin
                     type_d = src_chunk_type[8*i +: 8];
                     data_d = src_chunk_bytes[8*i +: 8];
                  end
               end
               state_d = ST_SYNC;
            end
         end
         ST_SYNC: begin
            tx_valid = 1'b1;
            tx_data  = SYNC_BYTE;
            if (tx_ready) state_d = ST_TYPE;
         end
         ST_TYPE: begin
            tx_valid = 1'b1;
            tx_data  = type_q;
            if (tx_ready) state_d = ST_DATA;
         end
         ST_DATA: begin
            tx_valid = 1'b1;
            tx_data  = data_q;
            if (tx_ready) state_d = ST_CSUM;
         end
         ST_CSUM: begin
            tx_valid = 1'b1;
            tx_data  = frame_csum(type_q, data_q);
            if (tx_ready) state_d = ST_ACK;
         end
         ST_ACK: begin
            src_ack = NUM_SOURCES'(1) << grant_q;
            ptr_d   = (grant_q == IDX_W'(NUM_SOURCES - 1)) ? '0 : grant_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         type_q  <= 8'h00;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         type_q  <= type_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_v_chunk_tx_framer.sv
// tb/tb_v_chunk_tx_framer.sv - directed self-checking bench for v_chunk_tx_framer
module tb_v_chunk_tx_framer;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [3:0]  src_should_update;
   logic [31:0] src_chunk_type;
   logic [31:0] src_chunk_bytes;
   logic [3:0]  src_ack;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   v_chunk_tx_framer #(
      .NUM_SOURCES (4),
      .SYNC_BYTE   (8'h7E)
   ) dut (
      .CLK               (CLK),
      .RST_N             (RST_N),
      .src_should_update (src_should_update),
      .src_chunk_type    (src_chunk_type),
      .src_chunk_bytes   (src_chunk_bytes),
      .src_ack           (src_ack),
      .tx_data           (tx_data),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .busy              (busy)
   );

   task automatic set_src(input int i, input logic [7:0] t, input logic [7:0] d);
      src_chunk_type[8*i +: 8]  = t;
      src_chunk_bytes[8*i +: 8] = d;
   endtask

   task automatic apply_reset();
      RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   // Collects one frame with tx_ready held high; returns bytes, acked index and cycles to first byte
   task automatic get_frame(input bit clear_on_ack, output logic [31:0] bytes, output int ack_idx,
                            output int lead, output bit ok);
      int nb;
      nb      = 0;
      bytes   = '0;
      ack_idx = -1;
      lead    = 0;
      ok      = 1'b0;
      for (int t = 1; t <= 40; t++) begin
         @(negedge CLK);
         if (tx_valid && tx_ready) begin
            if (nb == 0) lead = t;
            bytes = {bytes[23:0], tx_data};
            nb++;
         end else if (src_ack != 4'b0000 && nb == 4) begin
            if ($countones(src_ack) != 1) ack_idx = -2;
            else for (int i = 0; i < 4; i++) if (src_ack[i]) ack_idx = i;
            if (clear_on_ack) src_should_update = src_should_update & ~src_ack;
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      RST_N             = 1'b0;
      tx_ready          = 1'b1;
      src_should_update = 4'b0000;
      src_chunk_type    = '0;
      src_chunk_bytes   = '0;
      repeat (3) @(negedge CLK);
      n_cmp++;
      if ({tx_valid, busy, src_ack, tx_data} !== 14'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got valid=%b busy=%b ack=%b data=%h want all zero",
                  tx_valid, busy, src_ack, tx_data);
      end
      RST_N = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if ({tx_valid, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_idle: got valid=%b busy=%b want 0 0", tx_valid, busy);
      end
   endtask

   task automatic test_single();
      logic [31:0] exp;
      exp = 32'h7E02A5A7;
      set_src(0, 8'h02, 8'hA5);
      src_should_update = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         n_cmp++;
         if ({tx_valid, busy, tx_data} !== {2'b11, exp[31-8*k -: 8]}) begin
            n_bad++;
            $display("FAIL single_byte%0d: got valid=%b busy=%b data=%h want 1 1 %h",
                     k, tx_valid, busy, tx_data, exp[31-8*k -: 8]);
         end
      end
      @(negedge CLK);
      n_cmp++;
      if ({src_ack, tx_valid} !== 5'b00010) begin
         n_bad++;
         $display("FAIL single_ack: got ack=%b valid=%b want 0001 0", src_ack, tx_valid);
      end
      src_should_update = 4'b0000;
      @(negedge CLK);
      n_cmp++;
      if ({src_ack, busy, tx_valid} !== 6'b0) begin
         n_bad++;
         $display("FAIL single_after: got ack=%b busy=%b valid=%b want 0000 0 0", src_ack, busy, tx_valid);
      end
   endtask

   task automatic test_backpressure();
      set_src(0, 8'h02, 8'hA5);
      src_should_update = 4'b0001;
      @(negedge CLK);
      n_cmp++;
      if ({tx_valid, tx_data} !== 9'h17E) begin
         n_bad++;
         $display("FAIL bp_sync: got valid=%b data=%h want 1 7e", tx_valid, tx_data);
      end
      @(negedge CLK);
      n_cmp++;
      if ({tx_valid, tx_data} !== 9'h102) begin
         n_bad++;
         $display("FAIL bp_type: got valid=%b data=%h want 1 02", tx_valid, tx_data);
      end
      tx_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         n_cmp++;
         if ({tx_valid, busy, tx_data} !== {2'b11, 8'h02}) begin
            n_bad++;
            $display("FAIL bp_hold%0d: got valid=%b busy=%b data=%h want 1 1 02", k, tx_valid, busy, tx_data);
         end
      end
      tx_ready = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if ({tx_valid, tx_data} !== 9'h1A5) begin
         n_bad++;
         $display("FAIL bp_data: got valid=%b data=%h want 1 a5", tx_valid, tx_data);
      end
      @(negedge CLK);
      n_cmp++;
      if ({tx_valid, tx_data} !== 9'h1A7) begin
         n_bad++;
         $display("FAIL bp_csum: got valid=%b data=%h want 1 a7", tx_valid, tx_data);
      end
      @(negedge CLK);
      n_cmp++;
      if (src_ack !== 4'b0001) begin
         n_bad++;
         $display("FAIL bp_ack: got ack=%b want 0001", src_ack);
      end
      src_should_update = 4'b0000;
      @(negedge CLK);
   endtask

   task automatic test_rr_pair();
      logic [31:0] bytes;
      int          idx, lead;
      bit          ok;
      apply_reset();
      set_src(1, 8'h01, 8'h11);
      set_src(3, 8'h03, 8'h33);
      for (int r = 0; r < 2; r++) begin
         src_should_update = 4'b1010;
         get_frame(1'b1, bytes, idx, lead, ok);
         n_cmp++;
         if (!ok || idx !== 1 || bytes !== 32'h7E011110) begin
            n_bad++;
            $display("FAIL rr_pair%0d_first: got ok=%0d ack_idx=%0d bytes=%h want 1 1 7e011110", r, ok, idx, bytes);
         end
         get_frame(1'b1, bytes, idx, lead, ok);
         n_cmp++;
         if (!ok || idx !== 3 || bytes !== 32'h7E033330) begin
            n_bad++;
            $display("FAIL rr_pair%0d_second: got ok=%0d ack_idx=%0d bytes=%h want 1 3 7e033330", r, ok, idx, bytes);
         end
      end
      @(negedge CLK);
   endtask

   task automatic test_payload_change();
      logic [31:0] exp;
      exp = 32'h7E021012;
      set_src(2, 8'h02, 8'h10);
      src_should_update = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         if (k == 0) set_src(2, 8'h02, 8'h20);
         n_cmp++;
         if ({tx_valid, tx_data} !== {1'b1, exp[31-8*k -: 8]}) begin
            n_bad++;
            $display("FAIL payload_byte%0d: got valid=%b data=%h want 1 %h", k, tx_valid, tx_data, exp[31-8*k -: 8]);
         end
      end
      @(negedge CLK);
      n_cmp++;
      if (src_ack !== 4'b0100) begin
         n_bad++;
         $display("FAIL payload_ack: got ack=%b want 0100", src_ack);
      end
      src_should_update = 4'b0000;
      @(negedge CLK);
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] bytes;
      int          idx, lead;
      bit          ok, seen;
      set_src(0, 8'h02, 8'h55);
      src_should_update = 4'b0001;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge CLK);
         if (tx_valid && tx_data == 8'h55) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL midrst_reach_data: got no DATA byte 55 within 10 cycles want DATA byte");
      end
      RST_N = 1'b0;
      #1;
      n_cmp++;
      if ({tx_valid, busy, src_ack, tx_data} !== 14'h0) begin
         n_bad++;
         $display("FAIL midrst_drop: got valid=%b busy=%b ack=%b data=%h want all zero",
                  tx_valid, busy, src_ack, tx_data);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      get_frame(1'b1, bytes, idx, lead, ok);
      n_cmp++;
      if (!ok || idx !== 0 || bytes !== 32'h7E025557 || lead !== 1) begin
         n_bad++;
         $display("FAIL midrst_reframe: got ok=%0d ack_idx=%0d bytes=%h lead=%0d want 1 0 7e025557 1",
                  ok, idx, bytes, lead);
      end
      @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      logic [31:0] bytes, exp;
      logic [7:0]  t, d;
      int          idx, lead;
      bit          ok;
      apply_reset();
      for (int i = 0; i < 4; i++) set_src(i, 8'(i + 1), 8'(8'h40 + i));
      src_should_update = 4'b1111;
      for (int f = 0; f < 8; f++) begin
         t   = 8'((f % 4) + 1);
         d   = 8'(8'h40 + (f % 4));
         exp = {8'h7E, t, d, t ^ d};
         get_frame(1'b0, bytes, idx, lead, ok);
         n_cmp++;
         if (!ok || idx !== (f % 4) || bytes !== exp || lead !== ((f == 0) ? 1 : 2)) begin
            n_bad++;
            $display("FAIL b2b_frame%0d: got ok=%0d ack_idx=%0d bytes=%h lead=%0d want 1 %0d %h %0d",
                     f, ok, idx, bytes, lead, f % 4, exp, (f == 0) ? 1 : 2);
         end
      end
      src_should_update = 4'b0000;
      repeat (2) @(negedge CLK);
      n_cmp++;
      if ({busy, tx_valid, src_ack} !== 6'b0) begin
         n_bad++;
         $display("FAIL b2b_drain: got busy=%b valid=%b ack=%b want 0 0 0000", busy, tx_valid, src_ack);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_rr_pair();
      test_payload_change();
      test_reset_mid_frame();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
